// File: rtl/iomem_bus_fabric_pkg.sv
// Shared types and constants for the picosoc iomem peripheral fabric.
// Holds the FSM encoding, status-window layout and the saturating error-count helper.
package iomem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } fab_state_e;

    localparam logic [1:0] STAT_CTRL   = 2'd0;
    localparam logic [1:0] STAT_ADDR   = 2'd1;
    localparam int         STAT_TO_BIT = 16;
    localparam int         STAT_UM_BIT = 17;
    localparam int         ERR_CNT_W   = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERR_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/iomem_addr_decode.sv
// Priority decoder on addr[31:24]: status window flag plus lowest-index slave match.
module iomem_addr_decode
    import iomem_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = 2
) (
    input  logic [7:0]            addr_hi,
    input  logic [8*N_SLAVES-1:0] slave_base,
    input  logic [7:0]            status_base,
    output logic                  hit_slave,
    output logic                  hit_status,
    output logic [SEL_W-1:0]      sel_idx
);

    // scan from the top so a lower matching index overwrites a higher one
    always_comb begin
        hit_slave = 1'b0;
        sel_idx   = {SEL_W{1'b0}};
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            hit_slave = hit_slave | (slave_base[8*i +: 8] == addr_hi);
            sel_idx   = (slave_base[8*i +: 8] == addr_hi) ? SEL_W'(i) : sel_idx;
        end
    end

    assign hit_status = (addr_hi == status_base);

endmodule

// File: rtl/iomem_bus_fabric.sv
// Fabric between the picosoc iomem master and N slaves: decode, registered response,
// per-transaction timeout and a small error-log status window driving err_irq.
module iomem_bus_fabric
    import iomem_pkg::*;
#(
    parameter int                    N_SLAVES       = 4,
    parameter logic [8*N_SLAVES-1:0] SLAVE_BASE     = {8'h07, 8'h05, 8'h04, 8'h03},
    parameter logic [7:0]            STATUS_BASE    = 8'h0F,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_RDATA      = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [N_SLAVES-1:0]      s_valid,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [32*N_SLAVES-1:0]   s_rdata,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic                     err_irq
);

    localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TC_EN = (TIMEOUT_CYCLES != 0);

    fab_state_e           state_r;
    logic [SEL_W-1:0]     sel_r;
    logic [TCNT_W-1:0]    tcnt_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic                 to_flag_r;
    logic                 um_flag_r;
    logic [31:0]          last_addr_r;

    logic                 hit_slave_s;
    logic                 hit_status_s;
    logic [SEL_W-1:0]     sel_idx_s;
    logic [31:0]          stat_rdata_s;
    logic [31:0]          sel_rdata_s;

    iomem_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W)
    ) u_decode (
        .addr_hi     (m_addr[31:24]),
        .slave_base  (SLAVE_BASE),
        .status_base (STATUS_BASE),
        .hit_slave   (hit_slave_s),
        .hit_status  (hit_status_s),
        .sel_idx     (sel_idx_s)
    );

    // status window read view, selected by word offset
    always_comb begin
        stat_rdata_s = 32'h0000_0000;
        case (m_addr[3:2])
            STAT_CTRL: begin
                stat_rdata_s[ERR_CNT_W-1:0] = err_cnt_r;
                stat_rdata_s[STAT_TO_BIT]   = to_flag_r;
                stat_rdata_s[STAT_UM_BIT]   = um_flag_r;
            end
            STAT_ADDR: stat_rdata_s = last_addr_r;
            default:   stat_rdata_s = 32'h0000_0000;
        endcase
    end

    assign sel_rdata_s = s_rdata[32*int'(sel_r) +: 32];
    assign s_wstrb     = m_wstrb;
    assign s_addr      = m_addr;
    assign s_wdata     = m_wdata;
    assign err_irq     = to_flag_r | um_flag_r;

    // transaction sequencing, response register and error log
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            tcnt_r      <= {TCNT_W{1'b0}};
            err_cnt_r   <= {ERR_CNT_W{1'b0}};
            to_flag_r   <= 1'b0;
            um_flag_r   <= 1'b0;
            last_addr_r <= 32'h0000_0000;
            m_ready     <= 1'b0;
            m_rdata     <= 32'h0000_0000;
            s_valid     <= {N_SLAVES{1'b0}};
        end else begin
            m_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (hit_status_s) begin
                            m_rdata <= stat_rdata_s;
                            m_ready <= 1'b1;
                            state_r <= ST_RESP;
                            if ((m_addr[3:2] == STAT_CTRL) && (m_wstrb != 4'h0)) begin
                                err_cnt_r <= {ERR_CNT_W{1'b0}};
                                to_flag_r <= 1'b0;
                                um_flag_r <= 1'b0;
                            end
                        end else if (hit_slave_s) begin
                            sel_r   <= sel_idx_s;
                            s_valid <= N_SLAVES'(1) << sel_idx_s;
                            tcnt_r  <= {TCNT_W{1'b0}};
                            state_r <= ST_ACTIVE;
                        end else begin
                            m_rdata     <= ERR_RDATA;
                            m_ready     <= 1'b1;
                            state_r     <= ST_RESP;
                            um_flag_r   <= 1'b1;
                            err_cnt_r   <= sat_inc(err_cnt_r);
                            last_addr_r <= m_addr;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // a master that drops valid mid-flight is abandoned silently
                    if (!m_valid) begin
                        s_valid <= {N_SLAVES{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (s_ready[sel_r]) begin
                        m_rdata <= sel_rdata_s;
                        m_ready <= 1'b1;
                        s_valid <= {N_SLAVES{1'b0}};
                        state_r <= ST_RESP;
                    end else if (TC_EN && (tcnt_r == TC_LAST)) begin
                        m_rdata     <= ERR_RDATA;
                        m_ready     <= 1'b1;
                        s_valid     <= {N_SLAVES{1'b0}};
                        state_r     <= ST_RESP;
                        to_flag_r   <= 1'b1;
                        err_cnt_r   <= sat_inc(err_cnt_r);
                        last_addr_r <= m_addr;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_W'(1);
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
                default: begin
                    s_valid <= {N_SLAVES{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_bus_fabric.sv
// Scoreboard bench for iomem_bus_fabric: directed master transactions queue their
// expected response; monitors score each m_ready against the head of the queue.
`timescale 1ns/1ps
module tb_iomem_bus_fabric;
    import iomem_pkg::*;

    localparam int          N   = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic            m_valid, m_ready, err_irq;
    logic [3:0]      m_wstrb, s_wstrb;
    logic [31:0]     m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic [N-1:0]    s_valid, s_ready;
    logic [32*N-1:0] s_rdata;

    logic            b_m_valid, b_m_ready, b_err_irq;
    logic [3:0]      b_m_wstrb, b_s_wstrb;
    logic [31:0]     b_m_addr, b_m_wdata, b_m_rdata, b_s_addr, b_s_wdata;
    logic [N-1:0]    b_s_valid, b_s_ready;
    logic [32*N-1:0] b_s_rdata;

    iomem_bus_fabric #(
        .N_SLAVES(N), .SLAVE_BASE(32'h0705_0403), .STATUS_BASE(8'h0F),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(ERR)
    ) dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_ready(m_ready),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .err_irq(err_irq)
    );

    iomem_bus_fabric #(
        .N_SLAVES(N), .SLAVE_BASE(32'h0504_0503), .STATUS_BASE(8'h0F),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(ERR)
    ) dut_ov (
        .clk(clk), .resetn(resetn), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_wstrb(b_m_wstrb), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_rdata(b_s_rdata), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata), .err_irq(b_err_irq)
    );

    assign b_s_ready = b_s_valid;
    assign b_s_rdata = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

    typedef struct {
        logic [31:0]  rdata;
        bit           chk_rd;
        logic [N-1:0] mask;
        int           svc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t sb_b[$];
    exp_t e_a, e_b;
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // slave models: ready once s_valid has been seen for wait+1 cycles; -1 never answers
    int           wait_cyc [N];
    logic [31:0]  sl_data  [N];
    int           sv_cnt   [N];
    logic [N-1:0] stray_rdy;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            sv_cnt[i]  = s_valid[i] ? sv_cnt[i] + 1 : 0;
            s_ready[i] = stray_rdy[i] |
                         (s_valid[i] && (wait_cyc[i] >= 0) && (sv_cnt[i] == wait_cyc[i] + 1));
            s_rdata[32*i +: 32] = sl_data[i];
        end
    end

    // monitor for the main instance
    int           lat_a = 0;
    int           svc_a = 0;
    logic [N-1:0] mask_a = '0;
    always @(negedge clk) begin
        if (s_valid != 4'b0000) begin
            svc_a++;
            mask_a |= s_valid;
        end
        if (m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_m_ready", 32'(m_ready), 32'd0);
            end else begin
                e_a = sb.pop_front();
                if (e_a.chk_rd) chk("m_rdata", m_rdata, e_a.rdata);
                chk("s_valid_mask", 32'(mask_a), 32'(e_a.mask));
                chk("s_valid_cycles", 32'(svc_a), 32'(e_a.svc));
                chk("latency", 32'(lat_a), 32'(e_a.lat));
                chk("s_addr_pass", s_addr, m_addr);
                chk("s_wdata_pass", s_wdata, m_wdata);
                chk("s_wstrb_pass", 32'(s_wstrb), 32'(m_wstrb));
            end
        end
        if (!resetn || !m_valid) begin
            lat_a  = 0;
            svc_a  = 0;
            mask_a = '0;
        end else begin
            lat_a++;
        end
    end

    // monitor for the overlapping-base instance
    logic [N-1:0] mask_b = '0;
    always @(negedge clk) begin
        mask_b |= b_s_valid;
        if (b_m_ready) begin
            if (sb_b.size() == 0) begin
                chk("ov_unexpected_m_ready", 32'(b_m_ready), 32'd0);
            end else begin
                e_b = sb_b.pop_front();
                chk("ov_m_rdata", b_m_rdata, e_b.rdata);
                chk("ov_s_valid_mask", 32'(mask_b), 32'(e_b.mask));
            end
        end
        if (!b_m_valid) mask_b = '0;
    end

    task automatic wait_ready(input bit on_b);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = on_b ? b_m_ready : m_ready;
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL m_ready_timeout: no m_ready within 40 cycles (ov=%0d)", on_b);
            if (on_b) sb_b.delete(); else sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                       input logic [31:0] rd, input bit chk_rd, input logic [N-1:0] mask,
                       input int svc, input int lat);
        exp_t e;
        e.rdata = rd; e.chk_rd = chk_rd; e.mask = mask; e.svc = svc; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = a; m_wstrb = ws; m_wdata = wd;
        wait_ready(1'b0);
        m_valid = 1'b0;
    endtask

    task automatic req_b(input logic [31:0] a, input logic [31:0] rd, input logic [N-1:0] mask);
        exp_t e;
        e.rdata = rd; e.chk_rd = 1'b1; e.mask = mask; e.svc = 1; e.lat = 2;
        sb_b.push_back(e);
        @(posedge clk); #1;
        b_m_valid = 1'b1; b_m_addr = a;
        wait_ready(1'b1);
        b_m_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        resetn = 1'b0; stray_rdy = '0;
        m_valid = 1'b0; m_wstrb = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        b_m_valid = 1'b0; b_m_wstrb = 4'h0; b_m_addr = 32'h0; b_m_wdata = 32'h0;
        for (int i = 0; i < N; i++) begin
            wait_cyc[i] = 0;
            sl_data[i]  = 32'hC000_0000 + 32'(i);
            sv_cnt[i]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_err_irq", 32'(err_irq), 32'd0);
        resetn = 1'b1;

        // slave 2 read with three wait states; unselected slaves shout ready throughout
        wait_cyc[2] = 3; sl_data[2] = 32'h1234_5678; stray_rdy = 4'b1011;
        req(32'h0500_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 4'b0100, 4, 5);
        stray_rdy = 4'b0000;
        wait_cyc[1] = 0; sl_data[1] = 32'hAAAA_5555;
        req(32'h0400_0020, 4'hF, 32'hCAFE_F00D, 32'hAAAA_5555, 1'b1, 4'b0010, 1, 2);

        // unmapped access and its log entry
        req(32'h0900_0000, 4'h0, 32'h0, ERR, 1'b1, 4'b0000, 0, 1);
        chk("irq_after_unmapped", 32'(err_irq), 32'd1);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0002_0001, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0004, 4'h0, 32'h0, 32'h0900_0000, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0008, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 4'b0000, 0, 1);

        // timeout, then a ready landing exactly in the expiry cycle
        wait_cyc[0] = -1;
        req(32'h0300_0000, 4'h0, 32'h0, ERR, 1'b1, 4'b0001, 8, 9);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0003_0002, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0004, 4'h0, 32'h0, 32'h0300_0000, 1'b1, 4'b0000, 0, 1);
        wait_cyc[0] = 7; sl_data[0] = 32'h5A5A_0007;
        req(32'h0300_0040, 4'h0, 32'h0, 32'h5A5A_0007, 1'b1, 4'b0001, 8, 9);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0003_0002, 1'b1, 4'b0000, 0, 1);

        // clear, ignored address write
        req(32'h0F00_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b0000, 0, 1);
        chk("irq_after_clear", 32'(err_irq), 32'd0);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0004, 4'hF, 32'h1111_1111, 32'h0, 1'b0, 4'b0000, 0, 1);
        req(32'h0F00_0004, 4'h0, 32'h0, 32'h0300_0000, 1'b1, 4'b0000, 0, 1);

        // count saturation, starting just below the ceiling
        force dut.err_cnt_r = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_cnt_r;
        req(32'h2000_0000, 4'h0, 32'h0, ERR, 1'b1, 4'b0000, 0, 1);
        req(32'h2100_0000, 4'h0, 32'h0, ERR, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0002_FFFF, 1'b1, 4'b0000, 0, 1);
        req(32'h0F00_0004, 4'h0, 32'h0, 32'h2100_0000, 1'b1, 4'b0000, 0, 1);

        // async reset while a slave is being held
        wait_cyc[3] = -1;
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h0700_0000; m_wstrb = 4'h0;
        for (int c = 0; c < 5 && s_valid[3] !== 1'b1; c++) @(negedge clk);
        chk("sv3_before_reset", 32'(s_valid), 32'd8);
        #1 resetn = 1'b0;
        #1;
        chk("sv_async_reset", 32'(s_valid), 32'd0);
        chk("m_ready_in_reset", 32'(m_ready), 32'd0);
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_after_reset", 32'(err_irq), 32'd0);
        resetn = 1'b1;
        wait_cyc[3] = 1; sl_data[3] = 32'h0BAD_CAFE;
        req(32'h0700_0004, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b1, 4'b1000, 2, 3);
        req(32'h0F00_0000, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 4'b0000, 0, 1);

        // overlapping bases: lowest index wins
        req_b(32'h0512_3456, 32'hB000_0001, 4'b0010);
        req_b(32'h0400_0000, 32'hB000_0002, 4'b0100);
        req_b(32'h0300_0000, 32'hB000_0000, 4'b0001);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size() + sb_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
